// File: rtl/hazard_pkg.sv
// Shared hazard-interface definitions: Tnew width, bubble constants, MDU opcodes.
// Imported by tnew_tracker and the stall control unit so both ends agree.
package hazard_pkg;

    localparam int TNEW_W = 4;

    localparam logic [4:0]        REG_ZERO  = 5'd0;
    localparam logic [TNEW_W-1:0] TNEW_ZERO = '0;

    typedef enum logic [1:0] {
        MDOP_NONE = 2'b00,
        MDOP_MULT = 2'b01,
        MDOP_DIV  = 2'b10,
        MDOP_RSVD = 2'b11
    } mdop_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    function automatic logic [3:0] md_dec(input logic [3:0] x);
        return (x != 4'd0) ? x - 4'd1 : 4'd0;
    endfunction

endpackage

// File: rtl/tnew_stage.sv
// One pipeline slot holding {WAddr, Tnew}: bubble load, optional saturating
// decrement of the incoming Tnew, and zeroing of Tnew for WAddr=0 entries.
module tnew_stage #(
    parameter int TNEW_W = 4,
    parameter bit DEC_EN = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bubble_i,
    input  logic [4:0]        waddr_i,
    input  logic [TNEW_W-1:0] tnew_i,
    output logic [4:0]        waddr_o,
    output logic [TNEW_W-1:0] tnew_o
);
    import hazard_pkg::*;

    logic [4:0]        waddr_q, waddr_d;
    logic [TNEW_W-1:0] tnew_q, tnew_d;
    logic [TNEW_W-1:0] tnew_in;

    always_comb begin
        tnew_in = tnew_i;
        if (DEC_EN && (tnew_i != '0)) begin
            tnew_in = tnew_i - TNEW_W'(1);
        end
        waddr_d = waddr_i;
        tnew_d  = tnew_in;
        if (bubble_i || (waddr_i == REG_ZERO)) begin
            waddr_d = REG_ZERO;
            tnew_d  = TNEW_W'(TNEW_ZERO);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            waddr_q <= REG_ZERO;
            tnew_q  <= TNEW_W'(TNEW_ZERO);
        end else begin
            waddr_q <= waddr_d;
            tnew_q  <= tnew_d;
        end
    end

    assign waddr_o = waddr_q;
    assign tnew_o  = tnew_q;

endmodule

// File: rtl/tnew_tracker.sv
// Producer side of the hazard interface: carries {WAddr, Tnew} through E/M/W.
// Define TTU_MDU_TRACK_EN to build the MDU occupancy counter behind TTU_o_MDBusy.
module tnew_tracker #(
    parameter int TNEW_W         = hazard_pkg::TNEW_W,
    parameter int MD_MULT_CYCLES = hazard_pkg::MD_MULT_CYCLES,
    parameter int MD_DIV_CYCLES  = hazard_pkg::MD_DIV_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        TTU_i_D_WAddr,
    input  logic [TNEW_W-1:0] TTU_i_D_Tnew,
    input  logic              TTU_i_Stall,
    input  logic              TTU_i_Flush,
    input  logic [1:0]        TTU_i_E_MDOp,
    output logic [4:0]        TTU_o_E_WAddr,
    output logic [TNEW_W-1:0] TTU_o_E_Tnew,
    output logic [4:0]        TTU_o_M_WAddr,
    output logic [TNEW_W-1:0] TTU_o_M_Tnew,
    output logic [4:0]        TTU_o_W_WAddr,
    output logic [TNEW_W-1:0] TTU_o_W_Tnew,
    output logic              TTU_o_MDBusy
);
    import hazard_pkg::*;

    // A stall only injects a bubble into E; M and W keep draining.
    tnew_stage #(.TNEW_W(TNEW_W), .DEC_EN(1'b0)) u_e (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (TTU_i_Flush | TTU_i_Stall),
        .waddr_i  (TTU_i_D_WAddr),
        .tnew_i   (TTU_i_D_Tnew),
        .waddr_o  (TTU_o_E_WAddr),
        .tnew_o   (TTU_o_E_Tnew)
    );

    tnew_stage #(.TNEW_W(TNEW_W), .DEC_EN(1'b1)) u_m (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (TTU_i_Flush),
        .waddr_i  (TTU_o_E_WAddr),
        .tnew_i   (TTU_o_E_Tnew),
        .waddr_o  (TTU_o_M_WAddr),
        .tnew_o   (TTU_o_M_Tnew)
    );

    tnew_stage #(.TNEW_W(TNEW_W), .DEC_EN(1'b1)) u_w (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (TTU_i_Flush),
        .waddr_i  (TTU_o_M_WAddr),
        .tnew_i   (TTU_o_M_Tnew),
        .waddr_o  (TTU_o_W_WAddr),
        .tnew_o   (TTU_o_W_Tnew)
    );

`ifdef TTU_MDU_TRACK_EN
    logic [3:0] md_cnt_q, md_cnt_d;
    mdop_e      md_op;

    assign md_op = mdop_e'(TTU_i_E_MDOp);

    // Flush leaves the counter alone so an already-issued op still completes.
    always_comb begin
        md_cnt_d = md_dec(md_cnt_q);
        unique case (md_op)
            MDOP_MULT: md_cnt_d = 4'(MD_MULT_CYCLES);
            MDOP_DIV:  md_cnt_d = 4'(MD_DIV_CYCLES);
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_q <= 4'd0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign TTU_o_MDBusy = (md_cnt_q != 4'd0)
                        || (md_op == MDOP_MULT)
                        || (md_op == MDOP_DIV);
`else
    logic unused_mdop;
    assign unused_mdop  = ^TTU_i_E_MDOp;
    assign TTU_o_MDBusy = 1'b0;
`endif

endmodule

// File: tb/tb_tnew_tracker.sv
// Randomised scoreboard bench for tnew_tracker against a queue-free
// arithmetic model of the E/M/W slots and the MDU remaining-cycle count.
module tb_tnew_tracker;

    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    d_waddr;
    logic [TW-1:0] d_tnew;
    logic          stall, flush;
    logic [1:0]    mdop;
    logic [4:0]    e_waddr, m_waddr, w_waddr;
    logic [TW-1:0] e_tnew, m_tnew, w_tnew;
    logic          mdbusy;

    always #5 clk = ~clk;

    tnew_tracker #(.TNEW_W(TW)) dut (
        .clk           (clk),
        .reset         (reset),
        .TTU_i_D_WAddr (d_waddr),
        .TTU_i_D_Tnew  (d_tnew),
        .TTU_i_Stall   (stall),
        .TTU_i_Flush   (flush),
        .TTU_i_E_MDOp  (mdop),
        .TTU_o_E_WAddr (e_waddr),
        .TTU_o_E_Tnew  (e_tnew),
        .TTU_o_M_WAddr (m_waddr),
        .TTU_o_M_Tnew  (m_tnew),
        .TTU_o_W_WAddr (w_waddr),
        .TTU_o_W_Tnew  (w_tnew),
        .TTU_o_MDBusy  (mdbusy)
    );

    typedef struct {
        int ea, et, ma, mt, wa, wt;
        int busy;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Model state: stage slots 0=E, 1=M, 2=W and MDU cycles remaining.
    int sa[3];
    int st[3];
    int md_rem;

    function automatic int sdec(input int x);
        return (x > 0) ? x - 1 : 0;
    endfunction

    task automatic model_edge();
        if (reset || flush) begin
            for (int i = 0; i < 3; i++) begin
                sa[i] = 0;
                st[i] = 0;
            end
        end else begin
            sa[2] = sa[1];
            st[2] = sdec(st[1]);
            sa[1] = sa[0];
            st[1] = sdec(st[0]);
            if (stall || d_waddr == 0) begin
                sa[0] = stall ? 0 : 0;
                st[0] = 0;
            end else begin
                sa[0] = d_waddr;
                st[0] = d_tnew;
            end
        end
`ifdef TTU_MDU_TRACK_EN
        if (reset) md_rem = 0;
        else if (mdop == 2'b01) md_rem = 5;
        else if (mdop == 2'b10) md_rem = 10;
        else md_rem = sdec(md_rem);
`endif
    endtask

    task automatic push_exp();
        exp_t x;
        x.ea = sa[0]; x.et = st[0];
        x.ma = sa[1]; x.mt = st[1];
        x.wa = sa[2]; x.wt = st[2];
`ifdef TTU_MDU_TRACK_EN
        x.busy = (md_rem != 0 || mdop == 2'b01 || mdop == 2'b10) ? 1 : 0;
`else
        x.busy = 0;
`endif
        q.push_back(x);
    endtask

    task automatic cyc(input int a, input int t, input bit s, input bit f,
                       input int op, input bit r);
        @(posedge clk);
        #1;
        model_edge();
        d_waddr = 5'(a);
        d_tnew  = TW'(t);
        stall   = s;
        flush   = f;
        mdop    = 2'(op);
        reset   = r;
        push_exp();
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                exp_t x;
                x = q.pop_front();
                total++;
                if (int'(e_waddr) != x.ea || int'(e_tnew) != x.et ||
                    int'(m_waddr) != x.ma || int'(m_tnew) != x.mt ||
                    int'(w_waddr) != x.wa || int'(w_tnew) != x.wt ||
                    int'(mdbusy) != x.busy) begin
                    bad++;
                    $display("FAIL outputs t=%0t got E=%0d/%0d M=%0d/%0d W=%0d/%0d busy=%0d want E=%0d/%0d M=%0d/%0d W=%0d/%0d busy=%0d",
                             $time, e_waddr, e_tnew, m_waddr, m_tnew, w_waddr, w_tnew, mdbusy,
                             x.ea, x.et, x.ma, x.mt, x.wa, x.wt, x.busy);
                end
            end
        end
    end

    initial begin : driver
        sa = '{0, 0, 0};
        st = '{0, 0, 0};
        md_rem  = 0;
        reset   = 1'b1;
        d_waddr = '0;
        d_tnew  = '0;
        stall   = 1'b0;
        flush   = 1'b0;
        mdop    = 2'b00;

        // Reset edge, then drain {8,3} to zero.
        cyc(8, 3, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
        // Zero-address normalisation.
        cyc(0, 2, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // Stall: E={9,2} then D={10,1} stalled once.
        cyc(9, 2, 0, 0, 0, 0);
        cyc(10, 1, 1, 0, 0, 0);
        cyc(10, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // Fill {7,0},{6,1},{5,2} then Flush+Stall.
        cyc(7, 0, 0, 0, 0, 0);
        cyc(6, 1, 0, 0, 0, 0);
        cyc(5, 2, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // MDU: mult, then div reissued two cycles later, then idle.
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 2, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0, 0);
        // Large Tnew held undrained at W.
        cyc(31, 15, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
        // Reset with a div in flight and a full pipeline.
        cyc(3, 4, 0, 0, 2, 0);
        cyc(4, 5, 0, 0, 0, 0);
        cyc(12, 6, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            int a, op;
            a  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 31));
            op = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            cyc(a, int'($urandom_range(0, 15)),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0,
                op,
                $urandom_range(0, 49) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tnew_tracker.md
# tnew_tracker

Producer side of the pipeline hazard interface. The block captures each decoded instruction's destination register and Tnew at D, carries them through E, M and W, and decrements Tnew as the instruction ages. It drives the E/M write-address and Tnew values that the stall control unit compares against D-stage Tuse. It also optionally tracks multiply/divide unit occupancy for the same stall logic.

## Interface
Parameters:
- TNEW_W, default 4, width of every Tnew field.
- MD_MULT_CYCLES, default 5, busy cycles for a mult-class operation.
- MD_DIV_CYCLES, default 10, busy cycles for a div-class operation.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high; one clock with reset high clears all state.
- TTU_i_D_WAddr  in  5  destination register of the D-stage instruction; 0 means no write.
- TTU_i_D_Tnew  in  TNEW_W  Tnew of the D-stage instruction, measured at its arrival in E.
- TTU_i_Stall  in  1  D-stage stall from the stall control unit.
- TTU_i_Flush  in  1  cancels all in-flight E/M/W entries.
- TTU_i_E_MDOp  in  2  MDU start issued from E: 00 none, 01 mult-class, 10 div-class, 11 treated as none.
- TTU_o_E_WAddr / TTU_o_E_Tnew  out  5 / TNEW_W  E-stage entry.
- TTU_o_M_WAddr / TTU_o_M_Tnew  out  5 / TNEW_W  M-stage entry.
- TTU_o_W_WAddr / TTU_o_W_Tnew  out  5 / TNEW_W  W-stage entry.
- TTU_o_MDBusy  out  1  MDU occupied.

## Operation
- Bubble: WAddr=0, Tnew=0.
- Normalisation: an entry loaded with WAddr=0 always stores Tnew=0.
- dec(x): x-1 if x>0, else 0 (saturating).
- Per rising edge, in priority order:
  - reset: E, M and W load bubble; MDU counter loads 0.
  - Flush: E, M and W load bubble; MDU counter unaffected, so issued MDU ops complete.
  - Otherwise, all of the following:
    - E loads bubble if Stall, else the normalised {D_WAddr, D_Tnew}.
    - M loads {E_WAddr, dec(E_Tnew)}.
    - W loads {M_WAddr, dec(M_Tnew)}.
- Stall does not freeze M or W. Older instructions keep draining while the bubble enters E.
- D_Tnew up to 2^TNEW_W-1 is legal. Values that have not reached 0 by W are held as decremented, with no error signalled.
- MDU counter (4 bits), evaluated when not in reset:
  - E_MDOp=01 loads MD_MULT_CYCLES.
  - E_MDOp=10 loads MD_DIV_CYCLES.
  - Otherwise the counter applies dec().
  - A new op while the counter is nonzero reloads it (restart).
- MDBusy = (counter≠0) | (E_MDOp∈{01,10}). MDBusy is combinational on E_MDOp so a following instruction sees busy in the same cycle.

## Timing
- Reset value of every output is 0.
- D→E latency 1 cycle; E→M 1; M→W 1.
- An entry's Tnew drops by exactly 1 per stage until 0.
- A mult issued at edge N holds MDBusy high from the issue cycle through the cycle before edge N+5, then low. A div releases at edge N+10.
- Stall and Flush in the same cycle: Flush wins.
- Reset and Flush in the same cycle: reset wins; there is no difference in the result.
- Reset mid-MDU-operation drops MDBusy the cycle after the reset edge, unless E_MDOp is nonzero.

## Configuration
- TTU_MDU_TRACK_EN defined: MDU counter and MDBusy are built as above.
- TTU_MDU_TRACK_EN undefined: no counter is built; TTU_o_MDBusy is tied 0 and TTU_i_E_MDOp is ignored.
- Ports are identical in both builds.

## Structure
- hazard_pkg holds:
  - TNEW_W
  - bubble constants (REG_ZERO, TNEW_ZERO)
  - MDOp encodings (MDOP_NONE, MDOP_MULT, MDOP_DIV)
  - default MD_MULT_CYCLES / MD_DIV_CYCLES
- The stall control unit imports the same package so both ends share the Tnew width.
- One sub-module, tnew_stage: a registered {WAddr, Tnew} with bubble-load, optional dec() on input, and normalisation.
  - E instantiates it with dec disabled.
  - M and W instantiate it with dec enabled.
- The MDU counter lives in the top, under the macro.

## Test plan
- Drain: D={8,3} for one cycle, then bubbles → E={8,3}, then M={8,2}, then W={8,1}, then all-zero.
- Zero normalise: D={0,2} → E={0,0} next cycle.
- Stall: E={9,2}, D={10,1}, Stall=1 → next cycle E={0,0}, M={9,1}. Stall=0 on the following edge → E={10,1}.
- Flush with Stall: pipeline full of {5,2}/{6,1}/{7,0}; Flush=1, Stall=1 → E/M/W all zero next cycle.
- MDU (macro on): E_MDOp=01 at edge 0 → MDBusy=1 through cycle 4, 0 at cycle 5. Div reissued at cycle 2 → busy until cycle 12.
- Reset: assert reset for one edge with div in flight and a full pipeline → every output 0 on the next cycle.
